// File: rtl/sevenseg_pkg.sv
// Shared types, constants and the ASCII glyph table for the 7-segment scan driver.
// Glyphs are active-high {dp,g,f,e,d,c,b,a}; the driver inverts them for the pins.
package sevenseg_pkg;

   localparam int SEG_W  = 8;
   localparam int CHAR_W = 8;

   localparam logic [CHAR_W-1:0] CHAR_BLANK = 8'h20;

   localparam logic [SEG_W-1:0] GLYPH_0     = 8'h3F;
   localparam logic [SEG_W-1:0] GLYPH_1     = 8'h06;
   localparam logic [SEG_W-1:0] GLYPH_2     = 8'h5B;
   localparam logic [SEG_W-1:0] GLYPH_3     = 8'h4F;
   localparam logic [SEG_W-1:0] GLYPH_4     = 8'h66;
   localparam logic [SEG_W-1:0] GLYPH_5     = 8'h6D;
   localparam logic [SEG_W-1:0] GLYPH_6     = 8'h7D;
   localparam logic [SEG_W-1:0] GLYPH_7     = 8'h07;
   localparam logic [SEG_W-1:0] GLYPH_8     = 8'h7F;
   localparam logic [SEG_W-1:0] GLYPH_9     = 8'h6F;
   localparam logic [SEG_W-1:0] GLYPH_H     = 8'h74;
   localparam logic [SEG_W-1:0] GLYPH_E     = 8'h7B;
   localparam logic [SEG_W-1:0] GLYPH_L     = 8'h30;
   localparam logic [SEG_W-1:0] GLYPH_O     = 8'h5C;
   localparam logic [SEG_W-1:0] GLYPH_US    = 8'h08;
   localparam logic [SEG_W-1:0] GLYPH_W     = 8'h2A;
   localparam logic [SEG_W-1:0] GLYPH_R     = 8'h31;
   localparam logic [SEG_W-1:0] GLYPH_D     = 8'h5E;
   localparam logic [SEG_W-1:0] GLYPH_BANG  = 8'h82;
   localparam logic [SEG_W-1:0] GLYPH_DASH  = 8'h40;
   localparam logic [SEG_W-1:0] GLYPH_BLANK = 8'h00;

   function automatic logic [SEG_W-1:0] ascii_to_glyph(
      input logic [CHAR_W-1:0] c
   );
      logic [SEG_W-1:0] g;
      case (c)
         8'h30:   g = GLYPH_0;
         8'h31:   g = GLYPH_1;
         8'h32:   g = GLYPH_2;
         8'h33:   g = GLYPH_3;
         8'h34:   g = GLYPH_4;
         8'h35:   g = GLYPH_5;
         8'h36:   g = GLYPH_6;
         8'h37:   g = GLYPH_7;
         8'h38:   g = GLYPH_8;
         8'h39:   g = GLYPH_9;
         8'h68:   g = GLYPH_H;
         8'h65:   g = GLYPH_E;
         8'h6C:   g = GLYPH_L;
         8'h6F:   g = GLYPH_O;
         8'h5F:   g = GLYPH_US;
         8'h77:   g = GLYPH_W;
         8'h72:   g = GLYPH_R;
         8'h64:   g = GLYPH_D;
         8'h21:   g = GLYPH_BANG;
         8'h2D:   g = GLYPH_DASH;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// Combinational character-to-glyph lookup for the digit currently being scanned.
module sevenseg_glyph_rom
   import sevenseg_pkg::*;
(
   input  logic [CHAR_W-1:0] code_i,
   output logic [SEG_W-1:0]  glyph_o
);

   assign glyph_o = ascii_to_glyph(code_i);

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed N-digit common-anode 7-segment driver with guard band, PWM and load handshake.
// Optional per-digit blinking is built only when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan_mux
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int DWELL_LOG2    = 10,
   parameter int GUARD_CYCLES  = 8,
   parameter int BRIGHT_W      = 3,
   parameter bit ANODE_ACT_LOW = 1'b1
)(
   input  logic                         system1000,
   input  logic                         system1000_rst,
   input  logic [CHAR_W*NUM_DIGITS-1:0] load_chars,
   input  logic                         load_valid,
   output logic                         load_ready,
   input  logic [BRIGHT_W-1:0]          brightness,
   input  logic [NUM_DIGITS-1:0]        blink_mask,
   output logic [NUM_DIGITS-1:0]        anode,
   output logic [SEG_W-1:0]             seg,
   output logic                         frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS-1);
   localparam logic [DWELL_LOG2-1:0] GUARD_C = DWELL_LOG2'(GUARD_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACT_LOW}};

   logic [DWELL_LOG2-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
   logic [CHAR_W-1:0]     act_q [NUM_DIGITS];
   logic [CHAR_W-1:0]     act_d [NUM_DIGITS];
   logic [CHAR_W-1:0]     pend_q [NUM_DIGITS];
   logic [CHAR_W-1:0]     pend_d [NUM_DIGITS];
   logic                  pend_full_q, pend_full_d;
   logic [NUM_DIGITS-1:0] anode_q, anode_d;
   logic [SEG_W-1:0]      seg_q, seg_d;

   logic                  frame_end;
   logic                  accept;
   logic                  lit;
   logic                  blank;
   logic [BRIGHT_W-1:0]   dwell_top;
   logic [NUM_DIGITS-1:0] sel_onehot;
   logic [CHAR_W-1:0]     cur_char;
   logic [SEG_W-1:0]      cur_glyph;

   assign frame_end  = (dig_idx_q == LAST_IDX) && (dwell_cnt_q == '1);
   assign frame_done = frame_end && !system1000_rst;
   assign load_ready = !pend_full_q && !system1000_rst;
   assign accept     = load_valid && load_ready;

   assign dwell_top  = dwell_cnt_q[DWELL_LOG2-1 -: BRIGHT_W];
   assign sel_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx_q;
   assign cur_char   = act_q[dig_idx_q];

   sevenseg_glyph_rom u_rom (
      .code_i  (cur_char),
      .glyph_o (cur_glyph)
   );

`ifdef SEVENSEG_BLINK_EN
   logic [DWELL_LOG2+5:0] blink_cnt_q, blink_cnt_d;

   assign blink_cnt_d = blink_cnt_q + 1'b1;
   assign blank = blink_cnt_q[DWELL_LOG2+5] & blink_mask[dig_idx_q];

   always_ff @(posedge system1000) begin
      if (system1000_rst) blink_cnt_q <= '0;
      else                blink_cnt_q <= blink_cnt_d;
   end
`else
   logic unused_blink;

   assign unused_blink = ^blink_mask;
   assign blank = 1'b0;
`endif

   // Guard band first, then the PWM window from the dwell counter's top bits
   assign lit = (dwell_cnt_q >= GUARD_C) && (dwell_top < brightness) && !blank;

   always_comb begin
      dwell_cnt_d = dwell_cnt_q + 1'b1;
      dig_idx_d   = dig_idx_q;
      if (dwell_cnt_q == '1)
         dig_idx_d = (dig_idx_q == LAST_IDX) ? '0 : dig_idx_q + 1'b1;

      act_d       = act_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      // Commit only at the frame boundary so a new text always starts at digit 0
      if (frame_end && pend_full_q) begin
         act_d       = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            pend_d[i] = load_chars[CHAR_W*(NUM_DIGITS-i)-1 -: CHAR_W];
         pend_full_d = 1'b1;
      end

      anode_d = ANODE_OFF;
      seg_d   = '1;
      if (lit) begin
         anode_d = sel_onehot ^ ANODE_OFF;
         seg_d   = ~cur_glyph;
      end
   end

   always_ff @(posedge system1000) begin
      if (system1000_rst) begin
         dwell_cnt_q <= '0;
         dig_idx_q   <= '0;
         pend_full_q <= 1'b0;
         anode_q     <= ANODE_OFF;
         seg_q       <= '1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            act_q[i]  <= CHAR_BLANK;
            pend_q[i] <= CHAR_BLANK;
         end
      end else begin
         dwell_cnt_q <= dwell_cnt_d;
         dig_idx_q   <= dig_idx_d;
         pend_full_q <= pend_full_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
         act_q       <= act_d;
         pend_q      <= pend_d;
      end
   end

   assign anode = anode_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Directed bench for sevenseg_scan_mux at 4 digits, 16-cycle dwell, guard 2, 2-bit brightness.
module tb_sevenseg_scan_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] load_chars = '0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [1:0]  brightness = 2'd3;
   logic [3:0]  blink_mask = '0;
   logic [3:0]  anode;
   logic [7:0]  seg;
   logic        frame_done;

   int cyc = 0;
   int vectors = 0;
   int errors = 0;

`ifdef SEVENSEG_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   localparam logic [31:0] G_HELL = 32'h747B3030;
   localparam logic [31:0] G_A    = 32'h3F065B4F;
   localparam logic [31:0] G_B    = 32'h666D7D07;
   localparam logic [31:0] G_WR   = 32'h2A314082;
   localparam logic [31:0] G_MIX  = 32'h5E087400;

   always #5 clk = ~clk;

   // cyc equals the DUT dwell position counted from reset release
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   sevenseg_scan_mux #(
      .NUM_DIGITS    (4),
      .DWELL_LOG2    (4),
      .GUARD_CYCLES  (2),
      .BRIGHT_W      (2),
      .ANODE_ACT_LOW (1'b1)
   ) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .load_chars     (load_chars),
      .load_valid     (load_valid),
      .load_ready     (load_ready),
      .brightness     (brightness),
      .blink_mask     (blink_mask),
      .anode          (anode),
      .seg            (seg),
      .frame_done     (frame_done)
   );

   // Expected {anode,seg} sampled in cycle c (outputs lag the counters by one)
   function automatic logic [11:0] exp_out(
      input int          c,
      input logic [31:0] gl,
      input logic [1:0]  br,
      input logic [3:0]  bm
   );
      int         p;
      int         d;
      int         i;
      logic       on;
      logic [3:0] sel;
      p   = c - 1;
      d   = p % 16;
      i   = (p / 16) % 4;
      on  = (d >= 2) && ((d / 4) < int'(br));
      if (BLINK && bm[i] && ((p / 512) % 2 == 1)) on = 1'b0;
      sel = 4'b0001 << i;
      if (on) return {~sel, ~gl[31-8*i -: 8]};
      return {4'hF, 8'hFF};
   endfunction

   task automatic sync_fd();
      do @(negedge clk); while (cyc % 64 != 63);
   endtask

   task automatic test_reset();
      int found;
      repeat (2) @(negedge clk);
      vectors++;
      if ({anode, seg, load_ready, frame_done} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_out: got %h/%h/%b/%b want F/FF/0/0",
                  anode, seg, load_ready, frame_done);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (load_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", load_ready);
      end
      found = -1;
      for (int k = 0; k < 100 && found < 0; k++) begin
         if (frame_done === 1'b1) found = cyc;
         else @(negedge clk);
      end
      vectors++;
      if (found != 63) begin
         errors++;
         $display("FAIL first_frame_done: got cycle %0d want 63", found);
      end
   endtask

   task automatic test_load_hell();
      logic [11:0] e;
      @(negedge clk);
      load_chars = 32'h68656C6C;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      load_chars = $urandom;
      vectors++;
      if (load_ready !== 1'b0) begin
         errors++;
         $display("FAIL hell_accept: ready got %b want 0", load_ready);
      end
      sync_fd();
      vectors++;
      if ({frame_done, load_ready} !== 2'b10) begin
         errors++;
         $display("FAIL hell_fd: fd/ready got %b want 10", {frame_done, load_ready});
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 1) begin
            vectors++;
            if (load_ready !== 1'b1) begin
               errors++;
               $display("FAIL hell_ready_rise: got %b want 1", load_ready);
            end
         end
         e = exp_out(cyc, G_HELL, 2'd3, 4'h0);
         if (cyc % 64 == 4)  e = {4'hE, 8'h8B};
         if (cyc % 64 == 13) e = {4'hF, 8'hFF};
         if (cyc % 64 == 19) e = {4'hD, 8'h84};
         if (cyc % 64 == 40) e = {4'hB, 8'hCF};
         vectors++;
         if ({anode, seg} !== e) begin
            errors++;
            $display("FAIL hell_scan c%0d: got %h want %h", cyc, {anode, seg}, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      load_chars = 32'h30313233;
      load_valid = 1'b1;
      @(negedge clk);
      load_chars = 32'h34353637;
      do begin
         vectors++;
         if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold c%0d: ready got %b want 0", cyc, load_ready);
         end
         @(negedge clk);
      end while (cyc % 64 != 63);
      vectors++;
      if ({frame_done, load_ready} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_fd: fd/ready got %b want 10", {frame_done, load_ready});
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 1 || k == 2) begin
            vectors++;
            if (load_ready !== (k == 1)) begin
               errors++;
               $display("FAIL b2b_ready k%0d: got %b", k, load_ready);
            end
            if (k == 2) load_valid = 1'b0;
         end
         vectors++;
         if ({anode, seg} !== exp_out(cyc, G_A, 2'd3, 4'h0)) begin
            errors++;
            $display("FAIL b2b_frameA c%0d: got %h want %h", cyc,
                     {anode, seg}, exp_out(cyc, G_A, 2'd3, 4'h0));
         end
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         vectors++;
         if ({anode, seg} !== exp_out(cyc, G_B, 2'd3, 4'h0)) begin
            errors++;
            $display("FAIL b2b_frameB c%0d: got %h want %h", cyc,
                     {anode, seg}, exp_out(cyc, G_B, 2'd3, 4'h0));
         end
      end
   endtask

   task automatic test_simultaneous();
      load_chars = 32'h77722D21;
      load_valid = 1'b1;
      vectors++;
      if ({frame_done, load_ready} !== 2'b11) begin
         errors++;
         $display("FAIL simul_fd: fd/ready got %b want 11", {frame_done, load_ready});
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 1) load_valid = 1'b0;
         vectors++;
         if ({anode, seg} !== exp_out(cyc, G_B, 2'd3, 4'h0)) begin
            errors++;
            $display("FAIL simul_old c%0d: got %h want %h", cyc,
                     {anode, seg}, exp_out(cyc, G_B, 2'd3, 4'h0));
         end
      end
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         vectors++;
         if ({anode, seg} !== exp_out(cyc, G_WR, 2'd3, 4'h0)) begin
            errors++;
            $display("FAIL simul_new c%0d: got %h want %h", cyc,
                     {anode, seg}, exp_out(cyc, G_WR, 2'd3, 4'h0));
         end
      end
   endtask

   task automatic test_brightness();
      logic [11:0] e;
      brightness = 2'd0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         vectors++;
         if ({anode, seg} !== {4'hF, 8'hFF}) begin
            errors++;
            $display("FAIL bright0 c%0d: got %h want FFF", cyc, {anode, seg});
         end
      end
      brightness = 2'd1;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         e = exp_out(cyc, G_WR, 2'd1, 4'h0);
         if (cyc % 64 == 4) e = {4'hE, 8'hD5};
         if (cyc % 64 == 5) e = {4'hF, 8'hFF};
         vectors++;
         if ({anode, seg} !== e) begin
            errors++;
            $display("FAIL bright1 c%0d: got %h want %h", cyc, {anode, seg}, e);
         end
      end
      @(negedge clk);
      load_chars = 32'h645F687F;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      sync_fd();
      brightness = 2'd3;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         e = exp_out(cyc, G_MIX, 2'd3, 4'h0);
         if (cyc % 64 == 55) e = {4'h7, 8'hFF};
         vectors++;
         if ({anode, seg} !== e) begin
            errors++;
            $display("FAIL unknown_code c%0d: got %h want %h", cyc, {anode, seg}, e);
         end
      end
   endtask

   task automatic test_blink();
      blink_mask = 4'b0010;
      for (int k = 1; k <= 1024; k++) begin
         @(negedge clk);
         vectors++;
         if ({anode, seg} !== exp_out(cyc, G_MIX, 2'd3, blink_mask)) begin
            errors++;
            $display("FAIL blink c%0d: got %h want %h", cyc,
                     {anode, seg}, exp_out(cyc, G_MIX, 2'd3, blink_mask));
         end
      end
      blink_mask = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_load_hell();
      test_back_to_back();
      test_simultaneous();
      test_brightness();
      test_blink();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
